// File: rtl/alu_share_arb_pkg.sv
// rtl/alu_share_arb_pkg.sv - ALU opcodes, sequencer states and legal-op check
package alu_share_arb_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_SLL = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Any code outside the five implemented operations is flagged to the requester.
    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLL: legal = 1'b1;
            default:                                    legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arb_rr_pick.sv
// rtl/alu_share_arb_rr_pick.sv - combinational round-robin picker starting at rr_ptr
module alu_share_arb_rr_pick #(
    parameter int NREQ = 2,
    parameter int PTRW = 2
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [PTRW-1:0] rr_ptr,
    output logic            grant_valid,
    output logic [PTRW-1:0] grant_idx,
    output logic [NREQ-1:0] grant
);

    logic [NREQ-1:0] rot;
    logic [PTRW:0]   sum;

    // Rotate requests so bit 0 is rr_ptr, take the lowest set offset, map it back to an index.
    always_comb begin
        rot         = NREQ'({req_valid, req_valid} >> rr_ptr);
        grant_valid = 1'b0;
        grant_idx   = '0;
        sum         = '0;
        grant       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                grant_valid = 1'b1;
                sum         = {1'b0, rr_ptr} + (PTRW + 1)'(i);
                if (sum >= (PTRW + 1)'(NREQ)) begin
                    sum = sum - (PTRW + 1)'(NREQ);
                end
                grant_idx = sum[PTRW-1:0];
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            grant[j] = grant_valid && (grant_idx == PTRW'(j));
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// rtl/alu_share_arb.sv - round-robin sequencer sharing one single-cycle ALU among requesters
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PTRW = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    input  logic [4*NREQ-1:0]  req_op,
    input  logic [5*NREQ-1:0]  req_shamt,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic [3:0]         alu_op,
    output logic [4:0]         alu_shamt,
    input  logic [31:0]        alu_result,
    input  logic               alu_zero,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [31:0]        rsp_result,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic               busy
);

    state_t          state, state_next;
    logic [PTRW-1:0] rr_ptr, owner, grant_idx, ptr_after_owner;
    logic [NREQ-1:0] grant;
    logic            grant_valid, accept, rsp_fire;
    logic [31:0]     a_q, b_q, sel_a, sel_b;
    logic [3:0]      op_q, sel_op;
    logic [4:0]      shamt_q, sel_shamt;

    alu_share_arb_rr_pick #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_rr_pick (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant       (grant)
    );

    // One-hot mux of the granted requester's operation fields.
    always_comb begin
        sel_a     = '0;
        sel_b     = '0;
        sel_op    = '0;
        sel_shamt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a     = req_a[32*i +: 32];
                sel_b     = req_b[32*i +: 32];
                sel_op    = req_op[4*i +: 4];
                sel_shamt = req_shamt[5*i +: 5];
            end
        end
    end

    // Next state plus the handshake strobes; grants only happen from IDLE.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        accept     = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    accept     = 1'b1;
                    req_ready  = grant;
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                for (int i = 0; i < NREQ; i++) begin
                    rsp_valid[i] = (owner == PTRW'(i));
                end
                if (|(rsp_ready & rsp_valid)) begin
                    rsp_fire   = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign ptr_after_owner = (owner == PTRW'(NREQ - 1)) ? '0 : owner + PTRW'(1);

    // State, captured operation, response register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            shamt_q    <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner   <= grant_idx;
                a_q     <= sel_a;
                b_q     <= sel_b;
                op_q    <= sel_op;
                shamt_q <= sel_shamt;
            end
            if (state == ST_EXEC) begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_err    <= !op_is_legal(op_q);
            end
            if (rsp_fire) begin
                rr_ptr <= ptr_after_owner;
            end
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign alu_shamt = shamt_q;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// tb/tb_alu_share_arb.sv - self-checking bench for alu_share_arb
module tb_alu_share_arb;

    localparam int NREQ = 2;
    localparam int PTRW = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [32*NREQ-1:0] req_a, req_b;
    logic [4*NREQ-1:0]  req_op;
    logic [5*NREQ-1:0]  req_shamt;
    logic [31:0]        alu_a, alu_b, alu_result, rsp_result;
    logic [3:0]         alu_op;
    logic [4:0]         alu_shamt;
    logic               alu_zero, rsp_zero, rsp_err, busy;

    int checks  = 0;
    int errors  = 0;
    int exp_ptr = 0;
    int g;
    bit hold_valid = 1'b0;

    always #5 clk = ~clk;

    alu_share_arb #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_shamt  (req_shamt),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_shamt  (alu_shamt),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op, input logic [4:0] sh);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a - b;
            4'd4:    return b << sh;
            default: return 32'd0;
        endcase
    endfunction

    // Stand-in for the external ALU.
    always_comb begin
        alu_result = ref_alu(alu_a, alu_b, alu_op, alu_shamt);
        alu_zero   = (alu_a == alu_b);
    end

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int i = 0; i < NREQ; i++) begin
            if (v[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int i);
        logic [NREQ-1:0] v;
        v = '0;
        if (i >= 0 && i < NREQ) v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [4:0] sh);
        req_a[32*r +: 32]   = a;
        req_b[32*r +: 32]   = b;
        req_op[4*r +: 4]    = op;
        req_shamt[5*r +: 5] = sh;
    endtask

    // One full accept/exec/response sequence, starting just after a rising edge in IDLE.
    task automatic txn(input int stall, output int gi);
        logic [31:0] ea, eb, er;
        logic [3:0]  eo;
        logic [4:0]  es;
        @(negedge clk);
        gi = pick(req_valid, exp_ptr);
        chk("accept_ready", 32'(req_ready), 32'(onehot(gi)));
        chk("accept_busy", 32'(busy), 32'd0);
        if (gi < 0) begin
            @(posedge clk); #1;
            return;
        end
        ea = req_a[32*gi +: 32];
        eb = req_b[32*gi +: 32];
        eo = req_op[4*gi +: 4];
        es = req_shamt[5*gi +: 5];
        er = ref_alu(ea, eb, eo, es);
        @(posedge clk); #1;
        if (!hold_valid) req_valid[gi] = 1'b0;
        req_a[32*gi +: 32]   = $urandom;
        req_b[32*gi +: 32]   = $urandom;
        req_op[4*gi +: 4]    = 4'($urandom);
        req_shamt[5*gi +: 5] = 5'($urandom);
        @(negedge clk);
        chk("exec_alu_a", alu_a, ea);
        chk("exec_alu_b", alu_b, eb);
        chk("exec_alu_op", 32'(alu_op), 32'(eo));
        chk("exec_alu_shamt", 32'(alu_shamt), 32'(es));
        chk("exec_busy", 32'(busy), 32'd1);
        chk("exec_ready", 32'(req_ready), 32'd0);
        chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rsp_valid", 32'(rsp_valid), 32'(onehot(gi)));
        chk("rsp_result", rsp_result, er);
        chk("rsp_zero", 32'(rsp_zero), 32'(ea == eb));
        chk("rsp_err", 32'(rsp_err), 32'(eo > 4'd4));
        chk("rsp_ready_low", 32'(req_ready), 32'd0);
        rsp_ready = ~onehot(gi);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'(onehot(gi)));
            chk("stall_rsp_result", rsp_result, er);
            chk("stall_no_grant", 32'(req_ready), 32'd0);
        end
        rsp_ready = '1;
        @(posedge clk); #1;
        rsp_ready = '0;
        exp_ptr = (gi + 1) % NREQ;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Directed steps, then a randomized run against the reference model.
    initial begin
        reset     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_shamt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_result", rsp_result, 32'd0);
        chk("reset_rsp_zero", 32'(rsp_zero), 32'd0);
        chk("reset_rsp_err", 32'(rsp_err), 32'd0);
        chk("reset_alu_a", alu_a, 32'd0);
        chk("reset_alu_op", 32'(alu_op), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        set_req(0, 32'd5, 32'd7, 4'b0010, 5'd0);
        req_valid = 2'b01;
        txn(0, g);
        chk("add_owner", 32'(g), 32'd0);
        chk("add_result", rsp_result, 32'd12);

        set_req(1, 32'h1234, 32'h1234, 4'b0011, 5'd0);
        req_valid = 2'b10;
        txn(0, g);
        chk("sub_owner", 32'(g), 32'd1);
        chk("sub_zero", 32'(rsp_zero), 32'd1);

        set_req(0, 32'hFFFF_FFFF, 32'd1, 4'b0100, 5'd4);
        req_valid = 2'b01;
        txn(0, g);
        chk("sll_owner", 32'(g), 32'd0);
        chk("sll_result", rsp_result, 32'h10);

        set_req(1, 32'd3, 32'd4, 4'b0111, 5'd0);
        req_valid = 2'b10;
        txn(0, g);
        chk("illegal_result", rsp_result, 32'd0);
        chk("illegal_err", 32'(rsp_err), 32'd1);
        chk("illegal_zero", 32'(rsp_zero), 32'd0);

        hold_valid = 1'b1;
        req_valid  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            txn((k == 3) ? 5 : 0, g);
            chk("rr_order", 32'(g), 32'(k % 2));
        end
        hold_valid = 1'b0;
        req_valid  = '0;

        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        set_req(0, 32'd5, 32'd7, 4'b0010, 5'd0);
        req_valid = 2'b01;
        txn(0, g);
        set_req(1, 32'h55, 32'h66, 4'b0010, 5'd0);
        req_valid = 2'b10;
        @(negedge clk);
        chk("abort_accept", 32'(req_ready), 32'(onehot(pick(req_valid, exp_ptr))));
        @(posedge clk); #1;
        reset     = 1'b0;
        req_valid = 2'b11;
        set_req(0, 32'd9, 32'd9, 4'b0011, 5'd0);
        @(negedge clk);
        chk("abort_exec_busy", 32'(busy), 32'd1);
        chk("abort_exec_alu_a", alu_a, 32'h55);
        @(posedge clk); #1;
        reset   = 1'b1;
        exp_ptr = 0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_result", rsp_result, 32'd0);
        chk("abort_alu_a", alu_a, 32'd0);
        chk("abort_ptr_zero", 32'(req_ready), 32'b01);
        txn(0, g);
        chk("abort_first", 32'(g), 32'd0);
        txn(0, g);
        chk("abort_second", 32'(g), 32'd1);

        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < NREQ; r++) begin
                logic [31:0] a;
                int          sel;
                a   = $urandom;
                sel = $urandom_range(0, 9);
                set_req(r, a, ($urandom_range(0, 3) == 0) ? a : 32'($urandom),
                        (sel <= 7) ? 4'(sel) : 4'hF, 5'($urandom));
            end
            req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            txn($urandom_range(0, 2), g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
Round-robin arbiter and sequencer that shares the single-cycle 32-bit ALU among NREQ requesters, for example the main datapath and a future mult/div or address-calc unit. It accepts one operation at a time over a valid/ready request channel and drives the ALU from registered operands. It captures Result/Zero into a response register and holds the response until the owning requester acknowledges it. The ALU instance sits outside this block; this block only drives its inputs and samples its outputs.

Parameters:
NREQ, 2, number of requesters (2..4)
PTRW, 2, width of owner/round-robin pointer; must satisfy 2**PTRW >= NREQ

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk)
req_valid  input  NREQ  per-requester operation request
req_ready  output  NREQ  per-requester accept; one-hot or zero
req_a  input  32*NREQ  operand A, slice i = [32*i+31:32*i]
req_b  input  32*NREQ  operand B, same slicing
req_op  input  4*NREQ  ALUOp code, slice i = [4*i+3:4*i]
req_shamt  input  5*NREQ  shift amount, slice i = [5*i+4:5*i]
alu_a  output  32  to ALU A
alu_b  output  32  to ALU B
alu_op  output  4  to ALU ALUOp
alu_shamt  output  5  to ALU shamt
alu_result  input  32  from ALU Result
alu_zero  input  1  from ALU Zero (A==B)
rsp_valid  output  NREQ  per-requester response valid; one-hot or zero
rsp_ready  input  NREQ  per-requester response accept
rsp_result  output  32  registered result, shared by all requesters
rsp_zero  output  1  registered Zero
rsp_err  output  1  op code was not one of the legal codes
busy  output  1  1 in EXEC or RESP

Behaviour:
- FSM states: IDLE, EXEC, RESP. Reset (reset==0 at clk edge): state=IDLE, rr_ptr=0, owner=0, operand/op/shamt regs=0, rsp_result=0, rsp_zero=0, rsp_err=0. All outputs are then 0, except alu_* which reflect the zeroed regs.
- IDLE: search req_valid starting at index rr_ptr, wrapping modulo NREQ. The first asserted index g is granted. req_ready[g]=1 combinationally in the same cycle. On the edge, latch that requester's a, b, op and shamt plus owner=g, then go to EXEC. If no req_valid, stay in IDLE with req_ready=0.
- req_ready is asserted only in IDLE. A requester must hold valid and its operands stable until it sees ready.
- EXEC: alu_* are driven from the latched regs. These regs are stable from EXEC entry through RESP. On the edge, rsp_result<=alu_result and rsp_zero<=alu_zero. rsp_err<=1 if op is not in {0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 SLL B by shamt}. Then go to RESP.
- RESP: rsp_valid[owner]=1 and all other bits are 0. rsp_result, rsp_zero and rsp_err are held. When rsp_ready[owner]==1, on the edge go to IDLE and set rr_ptr=(owner+1) mod NREQ. rsp_ready bits of non-owners are ignored.
- Latency: accept at cycle T, response valid at T+2. Minimum spacing between accepts is 3 cycles, and it is longer if the response is back-pressured.
- Fairness: any requester holding valid is granted within NREQ grants.
- A requester that drops req_valid in IDLE before being granted is not an error; it is simply not granted.
- A mid-operation reset, in EXEC or RESP, aborts the operation with no response and returns to the reset values above.
- Illegal op: the ALU yields 0, the result is still delivered, and rsp_err=1.
- Zero is the ALU's A==B flag, not result==0. It is passed through unmodified.

Decomposition:
- Shared package/header alu_defs: ALUOp constants (ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_ADD=4'b0010, ALU_SUB=4'b0011, ALU_SLL=4'b0100), FSM state encodings, and the legal-op check.
- One natural sub-module, rr_pick: a combinational round-robin priority picker with inputs (req_valid, rr_ptr) and outputs (grant_valid, grant_idx, one-hot grant).

Test Plan:
- Single ADD: req0 with a=5, b=7, op=0010 at T. Required: req_ready[0] at T; alu_* = 5/7/0010 during T+1; rsp_valid[0] at T+2 with rsp_result=12, rsp_zero=0, rsp_err=0.
- SUB equal operands: req1 with a=b=0x1234, op=0011. Required: rsp_result=0, rsp_zero=1, response on bit 1 only.
- SLL uses B: a=0xFFFF_FFFF, b=1, shamt=4, op=0100. Required: rsp_result=0x10; req0 then receives its response.
- Round-robin: both req_valid held high for 4 operations, rsp_ready=1. Required grant order 0,1,0,1. Then hold rsp_ready[1]=0 for 5 cycles: rsp_valid[1] and rsp_result stay stable, and no new grant occurs.
- Illegal op 0111 with a=3, b=4. Required: rsp_result=0, rsp_err=1, rsp_zero=0.
- Reset mid-op: reset=0 in the EXEC cycle. Required: next cycle is IDLE, busy=0, rsp_valid=0, rr_ptr=0. A pending req1 is then granted only after req0's turn if req0 is valid.
